adder_rr_scheduler: RTL and testbench

//   Shares one WIDTH-bit unsigned adder among N_REQ requesters using round-robin arbitration.

---
 rtl/adder_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_adder_rr_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// adder_rr_scheduler : round-robin sharing of one WIDTH-bit adder among N_REQ
//                      valid/ready requesters, with an id-tagged result channel.
// Revision: 1.0
// ============================================================================
module adder_rr_scheduler #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH:0]         res_sum,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;

    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic [N_REQ-1:0] grant_oh;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx   = ID_W'(i);
                grant_found = 1'b1;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                grant_idx = ID_W'(i);
            end
        end
        grant_oh = grant_found ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            sum_q       <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            sum_q       <= sum_d;
            res_id_q    <= res_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        sum_d       = sum_q;
        res_id_d    = res_id_q;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so no accept strobe is seen while reset is asserted.
                req_ready = rst_n ? grant_oh : '0;
                if (grant_found) begin
                    a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sum_d       = {1'b0, a_q} + {1'b0, b_q};
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_sum   = sum_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_adder_rr_scheduler : directed and randomized checks of adder_rr_scheduler
//                         against a transaction-level round-robin model.
// Revision: 1.0
// ============================================================================
module tb_adder_rr_scheduler;
    localparam int WIDTH = 4;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a = '0;
    logic [N_REQ*WIDTH-1:0] req_b = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [WIDTH:0]         res_sum;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    adder_rr_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [WIDTH-1:0] opa [N_REQ];
    logic [WIDTH-1:0] opb [N_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = opb[i];
        end
    endtask

    // Reference arbiter: scan from the pointer with modular arithmetic.
    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Starts #1 after a rising edge with the DUT idle; returns #1 after the handshake edge.
    task automatic do_op(input logic [N_REQ-1:0] v, input int stall,
                         input logic [N_REQ-1:0] late, output int gid);
        int g;
        int esum;
        req_valid = v;
        drive_ops();
        @(negedge clk);
        g = rr_pick(v, m_ptr);
        gid = g;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("req_ready_grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk); #1;
        if (g < 0) return;
        esum = int'(opa[g]) + int'(opb[g]);
        opa[g] = WIDTH'($urandom);
        opb[g] = WIDTH'($urandom);
        drive_ops();
        @(negedge clk);
        chk("calc_busy", 32'(busy), 32'd1);
        chk("calc_res_valid", 32'(res_valid), 32'd0);
        chk("calc_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = v | late;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_sum", 32'(res_sum), 32'(esum));
            chk("stall_id", 32'(res_id), 32'(g));
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("hold_res_valid", 32'(res_valid), 32'd1);
        chk("hold_sum", 32'(res_sum), 32'(esum));
        chk("hold_id", 32'(res_id), 32'(g));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        m_ptr = (g + 1) % N_REQ;
    endtask

    initial begin
        int gid;
        for (int i = 0; i < N_REQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        drive_ops();
        req_valid = '1;

        // Reset state, with requests pending that must not be strobed.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'(res_sum), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester 1: 1+2.
        opa[1] = 4'd1; opb[1] = 4'd2;
        do_op(4'b0010, 0, 4'b0000, gid);
        chk("t1_gid", 32'(gid), 32'd1);

        // Carry kept: 15+15.
        opa[2] = 4'hF; opb[2] = 4'hF;
        do_op(4'b0100, 0, 4'b0000, gid);

        // Long result stall.
        do_op(4'b0001, 5, 4'b0000, gid);
        chk("t4_gid", 32'(gid), 32'd0);

        // Request 3 rises only in HOLD of request 0, then waits for IDLE.
        do_op(4'b0001, 1, 4'b1000, gid);
        do_op(4'b1000, 0, 4'b0000, gid);
        chk("t6_gid", 32'(gid), 32'd3);

        // Reset during CALC discards the operation.
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        @(posedge clk); #1;

        // Continuous requests from all: strict rotation starting at 0.
        for (int k = 0; k < 8; k++) begin
            do_op(4'b1111, 0, 4'b0000, gid);
            chk("rotation_id", 32'(gid), 32'(k % N_REQ));
        end

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            do_op(N_REQ'($urandom), int'($urandom_range(0, 3)), 4'b0000, gid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
